// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU defines: datapath width, EX-stage operation codes, MIPS opcode/funct constants.
// Pure declarations; no latency or flow control.
package alu_issue_stage_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        EXE_NO_OPERATION = 4'd0,
        EXE_ADD          = 4'd1,
        EXE_SUB          = 4'd2,
        EXE_AND          = 4'd3,
        EXE_OR           = 4'd4,
        EXE_SLT          = 4'd5,
        EXE_NOR          = 4'd6,
        EXE_SLL          = 4'd7,
        EXE_SRL          = 4'd8
    } exe_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode to ALU operation and operand-select controls.
// Latency: 0 cycles (pure logic); no backpressure.
module alu_ctrl_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr_id,
    output exe_op_e     exe_op,
    output logic        imm_sel,
    output logic        sext_sel,
    output logic        shamt_sel,
    output logic        illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = instr_id[31:26];
    assign w_funct         = instr_id[5:0];
    assign w_unused_fields = ^instr_id[25:6];

    always_comb begin
        exe_op    = EXE_NO_OPERATION;
        imm_sel   = 1'b0;
        sext_sel  = 1'b0;
        shamt_sel = 1'b0;
        illegal   = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                // Every R-type carries its shamt field through, not only shifts.
                shamt_sel = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: exe_op = EXE_ADD;
                    FN_SUB, FN_SUBU: exe_op = EXE_SUB;
                    FN_AND:          exe_op = EXE_AND;
                    FN_OR:           exe_op = EXE_OR;
                    FN_NOR:          exe_op = EXE_NOR;
                    FN_SLT:          exe_op = EXE_SLT;
                    FN_SLL:          exe_op = EXE_SLL;
                    FN_SRL:          exe_op = EXE_SRL;
                    default: begin
                        shamt_sel = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                exe_op   = EXE_ADD;
                imm_sel  = 1'b1;
                sext_sel = 1'b1;
            end
            OP_SLTI: begin
                exe_op   = EXE_SLT;
                imm_sel  = 1'b1;
                sext_sel = 1'b1;
            end
            OP_ANDI: begin
                exe_op  = EXE_AND;
                imm_sel = 1'b1;
            end
            OP_ORI: begin
                exe_op  = EXE_OR;
                imm_sel = 1'b1;
            end
            OP_BEQ: exe_op = EXE_SUB;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes instr_id, muxes operands, registers ALU inputs. Latency: 1 cycle.
// Backpressure: stall holds all EX registers; flush overrides stall and loads a bubble.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_id,
    input  logic             valid_id,
    input  logic [WIDTH-1:0] rs_val_id,
    input  logic [WIDTH-1:0] rt_val_id,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] val1,
    output logic [WIDTH-1:0] val2,
    output logic [4:0]       shamt,
    output logic [3:0]       alucontrol_exe,
    output logic             valid_exe,
    output logic             illegal_exe
);

    exe_op_e          w_exe_op;
    logic             w_imm_sel;
    logic             w_sext_sel;
    logic             w_shamt_sel;
    logic             w_illegal;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_val2;
    logic [4:0]       w_shamt;
    logic             w_unused_instr;

    exe_op_e          r_alucontrol;
    logic [WIDTH-1:0] r_val1;
    logic [WIDTH-1:0] r_val2;
    logic [4:0]       r_shamt;
    logic             r_valid;
    logic             r_illegal;

    alu_ctrl_decode u_decode (
        .instr_id  (instr_id),
        .exe_op    (w_exe_op),
        .imm_sel   (w_imm_sel),
        .sext_sel  (w_sext_sel),
        .shamt_sel (w_shamt_sel),
        .illegal   (w_illegal)
    );

    assign w_unused_instr = ^instr_id[31:16];

    assign w_imm_ext = w_sext_sel ? {{(WIDTH-16){instr_id[15]}}, instr_id[15:0]}
                                  : {{(WIDTH-16){1'b0}}, instr_id[15:0]};
    assign w_val2    = w_imm_sel ? w_imm_ext : rt_val_id;
    assign w_shamt   = w_shamt_sel ? instr_id[10:6] : 5'd0;

    // Priority: flush > stall > bubble (no valid) > illegal > normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alucontrol <= EXE_NO_OPERATION;
            r_val1       <= '0;
            r_val2       <= '0;
            r_shamt      <= '0;
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush || (!stall && !valid_id)) begin
            r_alucontrol <= EXE_NO_OPERATION;
            r_val1       <= '0;
            r_val2       <= '0;
            r_shamt      <= '0;
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!stall) begin
            r_valid <= 1'b1;
            if (w_illegal) begin
                r_alucontrol <= EXE_NO_OPERATION;
                r_val1       <= '0;
                r_val2       <= '0;
                r_shamt      <= '0;
                r_illegal    <= 1'b1;
            end else begin
                r_alucontrol <= w_exe_op;
                r_val1       <= rs_val_id;
                r_val2       <= w_val2;
                r_shamt      <= w_shamt;
                r_illegal    <= 1'b0;
            end
        end
    end

    assign val1           = r_val1;
    assign val2           = r_val2;
    assign shamt          = r_shamt;
    assign alucontrol_exe = r_alucontrol;
    assign valid_exe      = r_valid;
    assign illegal_exe    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expected EX-stage values.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_id;
    logic        valid_id;
    logic [31:0] rs_val_id;
    logic [31:0] rt_val_id;
    logic        stall;
    logic        flush;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [4:0]  shamt;
    logic [3:0]  alucontrol_exe;
    logic        valid_exe;
    logic        illegal_exe;

    int n_tests;
    int n_fail;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_id       (instr_id),
        .valid_id       (valid_id),
        .rs_val_id      (rs_val_id),
        .rt_val_id      (rt_val_id),
        .stall          (stall),
        .flush          (flush),
        .val1           (val1),
        .val2           (val2),
        .shamt          (shamt),
        .alucontrol_exe (alucontrol_exe),
        .valid_exe      (valid_exe),
        .illegal_exe    (illegal_exe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ex(input string tag, input logic [3:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [4:0] sh,
                            input logic vld, input logic ill);
        check({tag, ".op"},  64'(alucontrol_exe), 64'(op));
        check({tag, ".v1"},  64'(val1),           64'(v1));
        check({tag, ".v2"},  64'(val2),           64'(v2));
        check({tag, ".sh"},  64'(shamt),          64'(sh));
        check({tag, ".vld"}, 64'(valid_exe),      64'(vld));
        check({tag, ".ill"}, 64'(illegal_exe),    64'(ill));
    endtask

    task automatic check_bubble(input string tag);
        check_ex(tag, EXE_NO_OPERATION, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic vld);
        instr_id  = ins;
        rs_val_id = rs;
        rt_val_id = rt;
        valid_id  = vld;
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b_ins [8];
    logic [31:0] b_rs  [8];
    logic [31:0] b_rt  [8];
    logic [3:0]  b_op  [8];
    logic [31:0] b_v2  [8];
    logic [4:0]  b_sh  [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);

        b_ins[0] = rtype(FN_ADD, 5'd0);       b_rs[0] = 32'h5;        b_rt[0] = 32'h7;
        b_op[0]  = EXE_ADD; b_v2[0] = 32'h7;         b_sh[0] = 5'd0;
        b_ins[1] = rtype(FN_SUBU, 5'd2);      b_rs[1] = 32'h9;        b_rt[1] = 32'h3;
        b_op[1]  = EXE_SUB; b_v2[1] = 32'h3;         b_sh[1] = 5'd2;
        b_ins[2] = itype(OP_SLTI, 16'h8000);  b_rs[2] = 32'h1;        b_rt[2] = 32'hDEAD;
        b_op[2]  = EXE_SLT; b_v2[2] = 32'hFFFF8000;  b_sh[2] = 5'd0;
        b_ins[3] = itype(OP_ORI, 16'h8001);   b_rs[3] = 32'h20;       b_rt[3] = 32'hBEEF;
        b_op[3]  = EXE_OR;  b_v2[3] = 32'h00008001;  b_sh[3] = 5'd0;
        b_ins[4] = rtype(FN_NOR, 5'd0);       b_rs[4] = 32'hF0;       b_rt[4] = 32'h0F;
        b_op[4]  = EXE_NOR; b_v2[4] = 32'h0F;        b_sh[4] = 5'd0;
        b_ins[5] = rtype(FN_SRL, 5'd31);      b_rs[5] = 32'h0;        b_rt[5] = 32'h80000000;
        b_op[5]  = EXE_SRL; b_v2[5] = 32'h80000000;  b_sh[5] = 5'd31;
        b_ins[6] = itype(OP_BEQ, 16'h1234);   b_rs[6] = 32'h2;        b_rt[6] = 32'hAB;
        b_op[6]  = EXE_SUB; b_v2[6] = 32'hAB;        b_sh[6] = 5'd0;
        b_ins[7] = itype(OP_LW, 16'h0004);    b_rs[7] = 32'h100;      b_rt[7] = 32'h77;
        b_op[7]  = EXE_ADD; b_v2[7] = 32'h4;         b_sh[7] = 5'd0;

        #2;
        check_bubble("reset");
        step();
        rst_n = 1'b1;

        drive(itype(OP_ADDI, 16'hFFFF), 32'h10, 32'h55, 1'b1);
        step();
        check_ex("addi", EXE_ADD, 32'h10, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0);

        drive(itype(OP_ANDI, 16'hFFFF), 32'h10, 32'h55, 1'b1);
        step();
        check_ex("andi", EXE_AND, 32'h10, 32'h0000FFFF, 5'd0, 1'b1, 1'b0);

        drive(rtype(FN_SLL, 5'd5), 32'h99, 32'h3, 1'b1);
        step();
        check_ex("sll", EXE_SLL, 32'h99, 32'h3, 5'd5, 1'b1, 1'b0);

        drive(32'h0, 32'h7, 32'h8, 1'b1);
        step();
        check_ex("nop", EXE_SLL, 32'h7, 32'h8, 5'd0, 1'b1, 1'b0);

        drive({6'h3F, 26'h1234}, 32'hAA, 32'hBB, 1'b1);
        step();
        check_ex("ill_op", EXE_NO_OPERATION, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);

        drive(rtype(6'h3F, 5'd3), 32'hAA, 32'hBB, 1'b1);
        step();
        check_ex("ill_fn", EXE_NO_OPERATION, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);

        drive(rtype(FN_ADD, 5'd0), 32'h1, 32'h2, 1'b1);
        step();
        check_ex("add_clr", EXE_ADD, 32'h1, 32'h2, 5'd0, 1'b1, 1'b0);

        drive(rtype(FN_SUB, 5'd0), 32'h11, 32'h22, 1'b1);
        step();
        check_ex("sub", EXE_SUB, 32'h11, 32'h22, 5'd0, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(itype(OP_ANDI, 16'(i + 1)), 32'h300 + 32'(i), 32'h400, 1'b1);
            step();
            check_ex($sformatf("stall%0d", i), EXE_SUB, 32'h11, 32'h22, 5'd0, 1'b1, 1'b0);
        end
        flush = 1'b1;
        step();
        check_bubble("stall_flush");
        stall = 1'b0;

        drive(rtype(FN_OR, 5'd0), 32'h3, 32'h4, 1'b1);
        step();
        check_bubble("flush_only");
        flush = 1'b0;

        drive(rtype(FN_OR, 5'd0), 32'h3, 32'h4, 1'b0);
        step();
        check_bubble("no_valid");

        for (int i = 0; i < 8; i++) begin
            drive(b_ins[i], b_rs[i], b_rt[i], 1'b1);
            step();
            check_ex($sformatf("b2b%0d", i), b_op[i], b_rs[i], b_v2[i], b_sh[i], 1'b1, 1'b0);
        end

        drive(rtype(FN_ADD, 5'd0), 32'h3, 32'h4, 1'b1);
        step();
        check_ex("pre_rst", EXE_ADD, 32'h3, 32'h4, 5'd0, 1'b1, 1'b0);
        stall = 1'b1;
        drive(itype(OP_ANDI, 16'h00FF), 32'h9, 32'h9, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bubble("async_rst");
        step();
        check_bubble("rst_hold");
        rst_n = 1'b1;
        stall = 1'b0;
        drive(itype(OP_ORI, 16'h00F0), 32'h5, 32'h6, 1'b1);
        step();
        check_ex("post_rst", EXE_OR, 32'h5, 32'h000000F0, 5'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand/result datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_id  input  32  decode-stage instruction word.
REQ-005 valid_id  input  1  instr_id and operands valid this cycle.
REQ-006 rs_val_id  input  WIDTH  register-file value for rs.
REQ-007 rt_val_id  input  WIDTH  register-file value for rt.
REQ-008 stall  input  1  hold the EX-stage registers.
REQ-009 flush  input  1  replace the EX-stage contents with a bubble.
REQ-010 val1  output  WIDTH  registered ALU operand A.
REQ-011 val2  output  WIDTH  registered ALU operand B (register or extended immediate).
REQ-012 shamt  output  5  registered shift amount.
REQ-013 alucontrol_exe  output  4  registered ALU operation code.
REQ-014 valid_exe  output  1  EX-stage slot holds a real instruction.
REQ-015 illegal_exe  output  1  EX-stage instruction was not decodable.

Function
REQ-016 The block shall drive the ALU's operand and control inputs: decode instr_id to an EXE_* code combinationally, then register it into the EX stage.
REQ-017 R-type (opcode 0x00) funct mapping: 0x20/0x21->ADD, 0x22/0x23->SUB, 0x24->AND, 0x25->OR, 0x27->NOR, 0x2A->SLT, 0x00->SLL, 0x02->SRL; val1=rs_val_id, val2=rt_val_id, shamt=instr_id[10:6].
REQ-018 I-type mapping: 0x08/0x09/0x23/0x2B->ADD with sign-extended imm, 0x0A->SLT with sign-extended imm, 0x0C->AND and 0x0D->OR with zero-extended imm, 0x04->SUB with val2=rt_val_id; val1=rs_val_id; shamt=0.
REQ-019 Sign extension shall replicate instr_id[15] into bits WIDTH-1:16; zero extension shall fill them with 0.
REQ-020 Any other opcode/funct shall load alucontrol_exe=EXE_NO_OPERATION, val1=val2=0, shamt=0, illegal_exe=1, valid_exe=valid_id.
REQ-021 Latency: exactly one cycle from instr_id/valid_id sampled to EX outputs.
REQ-022 valid_id=0 (no stall/flush) shall load a bubble: alucontrol_exe=EXE_NO_OPERATION, val1=val2=0, shamt=0, valid_exe=0, illegal_exe=0.
REQ-023 stall=1 shall hold every output register unchanged; the decode input is ignored that cycle.
REQ-024 flush=1 shall load a bubble (REQ-022) regardless of stall or valid_id; flush has priority over stall.
REQ-025 All-zero instr_id (MIPS nop) shall decode as SLL with shamt 0, valid, not illegal.
REQ-026 Outputs shall be register outputs only; no combinational path from any input to any output.

Reset
REQ-027 rst_n low shall immediately (asynchronously) force val1=0, val2=0, shamt=0, alucontrol_exe=EXE_NO_OPERATION, valid_exe=0, illegal_exe=0.
REQ-028 Reset asserted mid-stall shall discard the held instruction; first post-reset edge shall load normally.

Structure
REQ-029 WIDTH, EXE_* codes (NO_OPERATION=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, NOR=6, SLL=7, SRL=8), and opcode/funct constants shall live in the shared defines package used by the ALU.
REQ-030 The combinational decode table shall be a sub-module alu_ctrl_decode (instr_id in; EXE code, imm-select, extend-select, illegal out); alu_issue_stage holds the operand muxes and EX registers.

Verification
REQ-031 Reset: rst_n low with outputs at arbitrary values -> all outputs 0 and alucontrol_exe=EXE_NO_OPERATION before the next clock edge.
REQ-032 Decode: addi rs_val=0x10, imm=0xFFFF -> next cycle val1=0x10, val2=0xFFFFFFFF, alucontrol_exe=ADD; andi imm=0xFFFF -> val2=0x0000FFFF, AND.
REQ-033 Shift: sll with shamt=5, rt_val=0x3 -> shamt=5, val2=0x3, alucontrol_exe=SLL, valid_exe=1.
REQ-034 Stall/flush: load sub, assert stall 3 cycles with new instr_id -> outputs unchanged; then stall=1 and flush=1 together -> bubble, valid_exe=0.
REQ-035 Illegal: opcode 0x3F, valid_id=1 -> alucontrol_exe=EXE_NO_OPERATION, illegal_exe=1, valid_exe=1; next valid add clears illegal_exe.
REQ-036 Back-to-back: 8 consecutive valid R/I instructions, no stalls -> each appears on outputs exactly one cycle later, in order, matching a reference decode model.
